// File: rtl/apb_downsizer_pkg.sv
// Shared types and constants for the 32-to-16 bit APB downsizer.
package apb_downsizer_pkg;

  localparam int HALF_W = 16;
  localparam int FULL_W = 32;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP_LO  = 3'd1,
    ST_ACCESS_LO = 3'd2,
    ST_SETUP_HI  = 3'd3,
    ST_ACCESS_HI = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  typedef struct packed {
    logic [HALF_W-1:0] wdata;
    logic [1:0]        strb;
  } lane_t;

endpackage

// File: rtl/apb_downsizer_if.sv
// Bus bundle for the downsizer: 32-bit master side and 16-bit slave side.
interface apb_downsizer_if
  import apb_downsizer_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic                psel_m_i;
  logic                penable_m_i;
  logic                pwrite_m_i;
  logic [ADDR_W-1:0]   paddr_m_i;
  logic [FULL_W-1:0]   pwdata_m_i;
  logic [3:0]          pstrb_m_i;
  logic [FULL_W-1:0]   prdata_m_o;
  logic                pready_m_o;
  logic                pslverr_m_o;

  logic                psel_s_o;
  logic                penable_s_o;
  logic                pwrite_s_o;
  logic [ADDR_W-1:0]   paddr_s_o;
  logic [HALF_W-1:0]   pwdata_s_o;
  logic [1:0]          pstrb_s_o;
  logic [HALF_W-1:0]   prdata_s_i;
  logic                pready_s_i;
  logic                pslverr_s_i;

  modport bridge (
    input  psel_m_i, penable_m_i, pwrite_m_i, paddr_m_i, pwdata_m_i, pstrb_m_i,
    output prdata_m_o, pready_m_o, pslverr_m_o,
    output psel_s_o, penable_s_o, pwrite_s_o, paddr_s_o, pwdata_s_o, pstrb_s_o,
    input  prdata_s_i, pready_s_i, pslverr_s_i
  );

  modport master (
    output psel_m_i, penable_m_i, pwrite_m_i, paddr_m_i, pwdata_m_i, pstrb_m_i,
    input  prdata_m_o, pready_m_o, pslverr_m_o
  );

  modport slave (
    input  psel_s_o, penable_s_o, pwrite_s_o, paddr_s_o, pwdata_s_o, pstrb_s_o,
    output prdata_s_i, pready_s_i, pslverr_s_i
  );
endinterface

// File: rtl/apb_downsizer.sv
// Splits each 32-bit APB transfer into up to two 16-bit slave transfers and
// reassembles read data before completing the master transfer.
module apb_downsizer
  import apb_downsizer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic            pclk,
  input logic            prst,
  apb_downsizer_if.bridge bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-3:0]   addr_q;
  logic [FULL_W-1:0]   wdata_q;
  logic [3:0]          strb_q;
  logic                write_q;
  logic                need_hi_q;
  logic                err_q;
  logic [FULL_W-1:0]   rdata_q;

  logic  capture, cap_need_lo, cap_need_hi;
  logic  lane, active, access;
  lane_t sel;

  function automatic lane_t lane_sel(input logic ln, input logic [FULL_W-1:0] wd,
                                     input logic [3:0] st, input logic wr);
    lane_t r;
    r.wdata = (ln == LANE_HI) ? wd[31:16] : wd[15:0];
    r.strb  = wr ? ((ln == LANE_HI) ? st[3:2] : st[1:0]) : 2'b00;
    return r;
  endfunction

  assign capture     = (state_q == ST_IDLE) && bus.psel_m_i && bus.penable_m_i;
  // Reads always fetch both halves; writes only touch lanes with strobes set.
  assign cap_need_lo = !bus.pwrite_m_i || (|bus.pstrb_m_i[1:0]);
  assign cap_need_hi = !bus.pwrite_m_i || (|bus.pstrb_m_i[3:2]);

  assign lane   = (state_q == ST_SETUP_HI) || (state_q == ST_ACCESS_HI);
  assign access = (state_q == ST_ACCESS_LO) || (state_q == ST_ACCESS_HI);
  assign active = access || (state_q == ST_SETUP_LO) || (state_q == ST_SETUP_HI);
  assign sel    = lane_sel(lane, wdata_q, strb_q, write_q);

  assign bus.psel_s_o    = active;
  assign bus.penable_s_o = access;
  assign bus.pwrite_s_o  = active && write_q;
  assign bus.paddr_s_o   = active ? {addr_q, lane, 1'b0} : '0;
  assign bus.pwdata_s_o  = active ? sel.wdata : '0;
  assign bus.pstrb_s_o   = active ? sel.strb : 2'b00;

  assign bus.pready_m_o  = (state_q == ST_DONE);
  assign bus.pslverr_m_o = (state_q == ST_DONE) && err_q;
  assign bus.prdata_m_o  = rdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          if (cap_need_lo)      state_d = ST_SETUP_LO;
          else if (cap_need_hi) state_d = ST_SETUP_HI;
          else                  state_d = ST_DONE;
        end
      end
      ST_SETUP_LO:  state_d = ST_ACCESS_LO;
      ST_SETUP_HI:  state_d = ST_ACCESS_HI;
      ST_ACCESS_LO: begin
        // A low-half error aborts the high half.
        if (bus.pready_s_i)
          state_d = (need_hi_q && !bus.pslverr_s_i) ? ST_SETUP_HI : ST_DONE;
      end
      ST_ACCESS_HI: if (bus.pready_s_i) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      write_q   <= 1'b0;
      need_hi_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q    <= bus.paddr_m_i[ADDR_W-1:2];
        wdata_q   <= bus.pwdata_m_i;
        strb_q    <= bus.pstrb_m_i;
        write_q   <= bus.pwrite_m_i;
        need_hi_q <= cap_need_hi;
        err_q     <= 1'b0;
        // Clearing here makes an aborted half read back as zero.
        if (!bus.pwrite_m_i) rdata_q <= '0;
      end
      if (access && bus.pready_s_i) begin
        err_q <= err_q | bus.pslverr_s_i;
        if (!write_q) begin
          if (lane == LANE_HI) rdata_q[31:16] <= bus.prdata_s_i;
          else                 rdata_q[15:0]  <= bus.prdata_s_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_downsizer.sv
// Randomised self-checking bench for apb_downsizer against a transaction-level model.
module tb_apb_downsizer;
  import apb_downsizer_pkg::*;

  localparam int ADDR_W = 32;

  logic pclk = 1'b0;
  logic prst = 1'b0;
  always #5 pclk = ~pclk;

  apb_downsizer_if #(.ADDR_W(ADDR_W)) bus ();

  apb_downsizer #(.ADDR_W(ADDR_W)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          waits;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  strb;
    logic        write;
  } acc_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  rsp_t rsp_q[$];
  acc_t seen_q[$];
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural 16-bit slave: takes one scripted response per access.
  initial begin : slave_model
    rsp_t cur;
    acc_t cur_acc;
    int   wcnt;
    cur = '{16'h0, 1'b0, 0};
    cur_acc = '0;
    wcnt = 0;
    bus.prdata_s_i  = '0;
    bus.pready_s_i  = 1'b0;
    bus.pslverr_s_i = 1'b0;
    forever begin
      @(negedge pclk);
      if (!prst) begin
        bus.pready_s_i  = 1'b0;
        bus.pslverr_s_i = 1'b0;
        bus.prdata_s_i  = '0;
      end else if (bus.psel_s_o && !bus.penable_s_o) begin
        if (rsp_q.size() > 0) cur = rsp_q.pop_front();
        else                  cur = '{16'h0, 1'b0, 0};
        cur_acc = '{bus.paddr_s_o, bus.pwdata_s_o, bus.pstrb_s_o, bus.pwrite_s_o};
        seen_q.push_back(cur_acc);
        wcnt = 0;
        bus.pready_s_i  = 1'b0;
        bus.pslverr_s_i = 1'b0;
      end else if (bus.psel_s_o && bus.penable_s_o) begin
        chk("slave stable", 64'({bus.paddr_s_o, bus.pwdata_s_o, bus.pstrb_s_o, bus.pwrite_s_o}),
            64'(cur_acc));
        if (wcnt == cur.waits) begin
          bus.pready_s_i  = 1'b1;
          bus.prdata_s_i  = cur.rdata;
          bus.pslverr_s_i = cur.err;
        end else begin
          wcnt++;
          bus.pready_s_i  = 1'b0;
          bus.prdata_s_i  = 16'($urandom);
          bus.pslverr_s_i = 1'b0;
        end
      end else begin
        bus.pready_s_i  = 1'b0;
        bus.pslverr_s_i = 1'b0;
      end
    end
  end

  task automatic master_idle();
    bus.psel_m_i    = 1'b0;
    bus.penable_m_i = 1'b0;
    bus.pwrite_m_i  = 1'b0;
    bus.paddr_m_i   = '0;
    bus.pwdata_m_i  = '0;
    bus.pstrb_m_i   = '0;
  endtask

  task automatic master_start(input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb);
    @(posedge pclk); #1;
    bus.psel_m_i    = 1'b1;
    bus.penable_m_i = 1'b0;
    bus.pwrite_m_i  = wr;
    bus.paddr_m_i   = addr;
    bus.pwdata_m_i  = wdata;
    bus.pstrb_m_i   = strb;
    @(posedge pclk); #1;
    bus.penable_m_i = 1'b1;
  endtask

  // One master transfer, predicted from the transfer rules and then observed.
  task automatic do_xfer(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input rsp_t lo, input rsp_t hi);
    acc_t        exp_q[$];
    logic        need_lo, need_hi, exp_err;
    logic [31:0] rd, exp_rd, base;
    int          lat, cyc;

    need_lo = !wr || (|strb[1:0]);
    need_hi = !wr || (|strb[3:2]);
    base    = {addr[31:2], 2'b00};
    lat     = 1;
    exp_err = 1'b0;
    rd      = '0;
    rsp_q.delete();
    seen_q.delete();
    if (need_lo) begin
      exp_q.push_back('{base, wdata[15:0], wr ? strb[1:0] : 2'b00, wr});
      rsp_q.push_back(lo);
      lat += 2 + lo.waits;
      exp_err |= lo.err;
      rd[15:0] = lo.rdata;
    end
    if (need_hi && !(need_lo && lo.err)) begin
      exp_q.push_back('{base + 32'd2, wdata[31:16], wr ? strb[3:2] : 2'b00, wr});
      rsp_q.push_back(hi);
      lat += 2 + hi.waits;
      exp_err |= hi.err;
      rd[31:16] = hi.rdata;
    end
    exp_rd = wr ? last_rd : rd;
    if (!wr) last_rd = rd;

    master_start(wr, addr, wdata, strb);
    @(posedge pclk);
    cyc = 0;
    forever begin
      #1;
      cyc++;
      if (bus.pready_m_o || cyc > 300) break;
      @(posedge pclk);
    end
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " pslverr"}, 64'(bus.pslverr_m_o), 64'(exp_err));
    chk({tag, " prdata"}, 64'(bus.prdata_m_o), 64'(exp_rd));
    @(posedge pclk); #1;
    master_idle();
    chk({tag, " pready pulse"}, 64'(bus.pready_m_o), 64'd0);
    chk({tag, " n_access"}, 64'(seen_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < seen_q.size())
        chk($sformatf("%s access%0d", tag, i), 64'(seen_q[i]), 64'(exp_q[i]));
  endtask

  initial begin : main
    rsp_t z;
    int   any_ready;
    z = '{16'h0, 1'b0, 0};
    master_idle();

    #2;
    chk("reset pready", 64'(bus.pready_m_o), 64'd0);
    chk("reset psel_s", 64'(bus.psel_s_o), 64'd0);
    chk("reset prdata", 64'(bus.prdata_m_o), 64'd0);
    chk("reset paddr_s", 64'(bus.paddr_s_o), 64'd0);
    repeat (2) @(posedge pclk);
    #1 prst = 1'b1;

    do_xfer("rd100", 1'b0, 32'h100, 32'h0, 4'h0, '{16'hBEEF, 1'b0, 0}, '{16'hDEAD, 1'b0, 0});
    do_xfer("wr40", 1'b1, 32'h40, 32'h12345678, 4'hF, z, z);
    do_xfer("wr44_hi", 1'b1, 32'h44, 32'hAABB0000, 4'hC, z, z);
    do_xfer("wr_nostrb", 1'b1, 32'h48, 32'hCAFEF00D, 4'h0, z, z);
    do_xfer("wr_lo", 1'b1, 32'h4C, 32'h0000C0DE, 4'h1, z, z);
    do_xfer("rd_err_lo", 1'b0, 32'h80, 32'h0, 4'h0, '{16'h1111, 1'b1, 0}, '{16'h2222, 1'b0, 0});
    do_xfer("rd_err_hi", 1'b0, 32'h84, 32'h0, 4'h0, '{16'h3333, 1'b0, 0}, '{16'h4444, 1'b1, 0});
    do_xfer("rd_wait3", 1'b0, 32'hC0, 32'h0, 4'h0, '{16'h5A5A, 1'b0, 3}, '{16'hA5A5, 1'b0, 3});
    do_xfer("wr_wait3", 1'b1, 32'hC4, 32'h87654321, 4'hF, '{16'h0, 1'b0, 3}, '{16'h0, 1'b0, 3});

    // Reset while the high half is waiting on the slave.
    rsp_q.delete();
    seen_q.delete();
    rsp_q.push_back('{16'h7777, 1'b0, 0});
    rsp_q.push_back('{16'h8888, 1'b0, 20});
    master_start(1'b0, 32'h300, 32'h0, 4'h0);
    for (int i = 0; i < 40; i++) begin
      @(posedge pclk); #1;
      if (bus.psel_s_o && bus.penable_s_o && bus.paddr_s_o[1]) break;
    end
    chk("hi access reached", 64'(bus.paddr_s_o), 64'h302);
    prst = 1'b0;
    #1;
    chk("rst psel_s", 64'(bus.psel_s_o), 64'd0);
    chk("rst penable_s", 64'(bus.penable_s_o), 64'd0);
    chk("rst paddr_s", 64'(bus.paddr_s_o), 64'd0);
    chk("rst prdata", 64'(bus.prdata_m_o), 64'd0);
    chk("rst pready", 64'(bus.pready_m_o), 64'd0);
    master_idle();
    rsp_q.delete();
    last_rd = '0;
    repeat (2) @(posedge pclk);
    #1 prst = 1'b1;
    any_ready = 0;
    repeat (8) begin
      @(posedge pclk); #1;
      if (bus.pready_m_o) any_ready++;
    end
    chk("no pready after reset", 64'(any_ready), 64'd0);
    do_xfer("rd200", 1'b0, 32'h200, 32'h0, 4'h0, '{16'h0123, 1'b0, 0}, '{16'h4567, 1'b0, 1});

    for (int t = 0; t < 40; t++) begin
      rsp_t lo, hi;
      lo = '{16'($urandom), ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3))};
      hi = '{16'($urandom), ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3))};
      do_xfer($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), $urandom,
              $urandom, 4'($urandom_range(0, 15)), lo, hi);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_downsizer.md
Name: apb_downsizer

Overview:
- Bridges a 32-bit APB master onto a 16-bit APB slave.
- Each 32-bit master transfer becomes one or two 16-bit slave transfers:
  - low half-word at byte offset 0, high half-word at offset 2.
  - Read data is reassembled before pready is returned to the master.
- Counterpart of the 16-to-32 upsizer. Sits between the 32-bit crypto-accelerator control bus and legacy 16-bit peripherals.

Parameters:
ADDR_W, 32, address width on both sides

Ports:
pclk          in   1        clock
prst          in   1        reset, asynchronous, active-low
psel_m_i      in   1        master select
penable_m_i   in   1        master enable (access phase)
pwrite_m_i    in   1        master direction, 1 = write
paddr_m_i     in   ADDR_W   master byte address
pwdata_m_i    in   32       master write data
pstrb_m_i     in   4        master byte strobes
prdata_m_o    out  32       assembled read data
pready_m_o    out  1        transfer complete, 1-cycle pulse
pslverr_m_o   out  1        error, valid with pready_m_o
psel_s_o      out  1        slave select
penable_s_o   out  1        slave enable
pwrite_s_o    out  1        slave direction
paddr_s_o     out  ADDR_W   slave address, bit0 = 0
pwdata_s_o    out  16       slave write data
pstrb_s_o     out  2        slave strobes
prdata_s_i    in   16       slave read data
pready_s_i    in   1        slave ready
pslverr_s_i   in   1        slave error

Behaviour:
- Reset (async, prst=0):
  - state IDLE; every output and internal latch = 0.
  - Reset mid-transfer abandons it; no pready_m_o is produced.
- All outputs come from flops or state decode. No combinational path from any input to any output.
- States: IDLE, SETUP_LO, ACCESS_LO, SETUP_HI, ACCESS_HI, DONE.
- Capture:
  - In IDLE, psel_m_i & penable_m_i latches addr, wdata, strb and write. A setup-only cycle (penable_m_i=0) is ignored.
  - Write: need_lo = |strb[1:0], need_hi = |strb[3:2].
  - Read: need_lo = need_hi = 1.
  - Next state: SETUP_LO if need_lo, else SETUP_HI if need_hi, else DONE (write with strb=0000 issues no slave access).
- SETUP_x: psel_s_o=1, penable_s_o=0.
  - paddr_s_o = {addr[ADDR_W-1:2], x==HI, 1'b0}.
  - pwdata_s_o = wdata[15:0] (LO) or wdata[31:16] (HI).
  - pstrb_s_o = strb[1:0] / strb[3:2] on writes, 00 on reads.
  - Always proceeds to ACCESS_x.
- ACCESS_x: psel_s_o=1, penable_s_o=1, other slave outputs held stable.
  - Waits indefinitely while pready_s_i=0.
  - On pready_s_i=1 (read): prdata_s_i is stored into bits [15:0] (LO) or [31:16] (HI).
  - On pready_s_i=1: err |= pslverr_s_i.
  - Next state is SETUP_HI if x==LO & need_hi & ~pslverr_s_i, else DONE. An error on the low half aborts the high half.
  - psel_s_o stays 1 from ACCESS_LO into SETUP_HI (back-to-back); penable_s_o drops to 0.
- DONE:
  - psel_s_o = penable_s_o = 0.
  - pready_m_o = 1 for exactly one cycle, with pslverr_m_o = err and prdata_m_o valid.
  - Next state IDLE.
- prdata_m_o:
  - Holds its value until the next read capture, which clears it.
  - A half not accessed (aborted) reads 0.
- Writes never modify prdata_m_o.
- Latency, zero-wait slave:
  - Full read or write: pready_m_o asserts 5 cycles after the capture edge.
  - Single-half write: 3 cycles.
  - strb=0000 write: 1 cycle.
- The next master transfer (setup then access) is accepted normally after DONE. The setup cycle has penable_m_i=0, so there is no double capture.

Decomposition:
- Package apb_downsizer_pkg:
  - state localparams (3-bit encoding)
  - LANE_LO=0 / LANE_HI=1
  - HALF_W=16, FULL_W=32
- No sub-module. Lane selection (address, wdata, strb mux) is a local function; one module of about 200 lines.

Test Plan:
- Read addr 0x100, slave returns 0xBEEF then 0xDEAD, zero wait:
  - slave sees 0x100 then 0x102, pstrb 00.
  - prdata_m_o = 0xDEADBEEF, pready_m_o 5 cycles after capture.
- Write 0x12345678, strb 1111, addr 0x40: slave sees (0x40, 0x5678, 11) then (0x42, 0x1234, 11); pslverr_m_o = 0.
- Write strb 1100, addr 0x44, data 0xAABB0000: single slave access (0x46, 0xAABB, 11). Write strb 0000: no psel_s_o, pready_m_o after 1 cycle.
- Read with pslverr_s_i=1 on the low half: no high-half access; pslverr_m_o = 1; prdata_m_o[31:16] = 0.
- Slave inserts 3 wait states per half: penable_s_o held 4 cycles each; address and data stable throughout; pready_m_o single pulse.
- prst low during ACCESS_HI: all outputs 0 immediately; after release a fresh read of 0x200 completes correctly.
